// File: rtl/sevenseg_scan_ctrl.sv
// sevenseg_scan_ctrl: multiplexed common-anode seven-segment scanner with dead-time and frame-aligned updates.
// Optional leading-zero blanking when SEVENSEG_LZB_EN is defined.
module sevenseg_scan_ctrl #(
    parameter int NDIG     = 4,
    parameter int PRESCALE = 1200,
    parameter int DEAD     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              upd_valid,
    output logic              upd_ready,
    input  logic [4*NDIG-1:0] upd_data,
    output logic              a,
    output logic              b,
    output logic              c,
    output logic              d,
    output logic              e,
    output logic              f,
    output logic              g,
    output logic [NDIG-1:0]   dig_n,
    output logic              frame_start
);
    localparam int TW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int DW = (NDIG > 1) ? $clog2(NDIG) : 1;

    typedef enum logic {BLANK, SHOW} slot_state_t;

    function automatic logic [6:0] decode(input logic [3:0] v);
        case (v)
            4'h0: decode = 7'b0000001;
            4'h1: decode = 7'b1001111;
            4'h2: decode = 7'b0010010;
            4'h3: decode = 7'b0000110;
            4'h4: decode = 7'b1001100;
            4'h5: decode = 7'b0100100;
            4'h6: decode = 7'b0100000;
            4'h7: decode = 7'b0001111;
            4'h8: decode = 7'b0000000;
            4'h9: decode = 7'b0000100;
            4'hA: decode = 7'b0001000;
            4'hB: decode = 7'b1100000;
            4'hC: decode = 7'b0110001;
            4'hD: decode = 7'b1000010;
            4'hE: decode = 7'b0110000;
            default: decode = 7'b0111000;
        endcase
    endfunction

    logic [TW-1:0]     tick_q, tick_d;
    logic [DW-1:0]     dig_q, dig_d;
    logic [4*NDIG-1:0] active_q, active_d, pending_q, pending_d;
    logic              pend_q, pend_d;
    logic [6:0]        seg_q, seg_d;
    logic [NDIG-1:0]   dig_n_q, dig_n_d;
    logic              fs_q, fs_d;
    logic              wrap_tick, wrap_dig, accept, apply, hidden, zero_above;
    slot_state_t       slot_state;

    always_comb begin
        wrap_tick  = tick_q == TW'(PRESCALE - 1);
        wrap_dig   = dig_q == DW'(NDIG - 1);
        tick_d     = (!en || wrap_tick) ? '0 : tick_q + TW'(1);
        dig_d      = !en ? '0 : wrap_tick ? (wrap_dig ? '0 : dig_q + DW'(1)) : dig_q;
        accept     = upd_valid && !pend_q;
        // with the scan stopped there is no frame to protect, so apply at once
        apply      = pend_q && (!en || (wrap_tick && wrap_dig));
        pending_d  = accept ? upd_data : pending_q;
        pend_d     = accept ? 1'b1 : apply ? 1'b0 : pend_q;
        active_d   = apply ? pending_q : active_q;
        slot_state = (en && tick_q >= TW'(DEAD)) ? SHOW : BLANK;
        hidden     = 1'b0;
        zero_above = 1'b1;
`ifdef SEVENSEG_LZB_EN
        for (int i = NDIG - 1; i >= 1; i--) begin
            zero_above = zero_above && (active_q[4*i +: 4] == 4'h0);
            if (dig_q == DW'(i)) hidden = zero_above;
        end
`endif
        seg_d   = (slot_state == SHOW) ? decode(active_q[{dig_q, 2'b00} +: 4]) : 7'h7F;
        dig_n_d = (slot_state == SHOW && !hidden) ? ~(NDIG'(1) << dig_q) : '1;
        fs_d    = en && tick_q == '0 && dig_q == '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tick_q    <= '0;
            dig_q     <= '0;
            active_q  <= '0;
            pending_q <= '0;
            pend_q    <= 1'b0;
            seg_q     <= 7'h7F;
            dig_n_q   <= '1;
            fs_q      <= 1'b0;
        end else begin
            tick_q    <= tick_d;
            dig_q     <= dig_d;
            active_q  <= active_d;
            pending_q <= pending_d;
            pend_q    <= pend_d;
            seg_q     <= seg_d;
            dig_n_q   <= dig_n_d;
            fs_q      <= fs_d;
        end
    end

    assign {a, b, c, d, e, f, g} = seg_q;
    assign dig_n       = dig_n_q;
    assign frame_start = fs_q;
    assign upd_ready   = !pend_q;
endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// tb_sevenseg_scan_ctrl: directed bench for sevenseg_scan_ctrl with NDIG=4, PRESCALE=20, DEAD=4.
module tb_sevenseg_scan_ctrl;
    logic        clk = 1'b0;
    logic        rst, en, upd_valid, upd_ready;
    logic [15:0] upd_data;
    logic        a, b, c, d, e, f, g, frame_start;
    logic [3:0]  dig_n;
    int          n_chk = 0, n_pass = 0, ph = 0;

    logic [6:0] seg_tab [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                 7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                 7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                                 7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

    sevenseg_scan_ctrl #(.NDIG(4), .PRESCALE(20), .DEAD(4)) dut (
        .clk(clk), .rst(rst), .en(en), .upd_valid(upd_valid), .upd_ready(upd_ready),
        .upd_data(upd_data), .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g),
        .dig_n(dig_n), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
        else n_pass++;
    endtask

    // {frame_start, dig_n, a..g} expected at phase p of an 80-cycle frame showing digits v
    function automatic logic [11:0] expv(input int p, input logic [15:0] v);
        int         t = p % 20;
        int         k = p / 20;
        logic [3:0] dn;
        if (t < 4) return {p == 0, 4'hF, 7'h7F};
        dn = ~(4'b0001 << k);
`ifdef SEVENSEG_LZB_EN
        if (k > 0 && (v >> (4 * k)) == 16'h0) dn = 4'hF;
`endif
        return {1'b0, dn, seg_tab[v[4*k +: 4]]};
    endfunction

    function automatic logic [11:0] outs();
        return {frame_start, dig_n, a, b, c, d, e, f, g};
    endfunction

    task automatic step(input logic [15:0] shown);
        @(negedge clk);
        check($sformatf("scan ph%0d", ph), 32'(outs()), 32'(expv(ph, shown)));
        ph = (ph + 1) % 80;
    endtask

    task automatic steps(input int n, input logic [15:0] shown);
        repeat (n) step(shown);
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; upd_valid = 1'b0; upd_data = 16'h0;
        repeat (3) @(negedge clk);
        check("rst_outs", 32'(outs()), 32'({1'b0, 4'hF, 7'h7F}));
        check("rst_ready", 32'(upd_ready), 32'd1);
        rst = 1'b0;
        steps(160, 16'h0000);
        // update mid-frame
        steps(30, 16'h0000);
        upd_valid = 1'b1; upd_data = 16'h8F31;
        step(16'h0000);
        check("rdy_drop", 32'(upd_ready), 32'd0);
        upd_valid = 1'b0; upd_data = 16'hFFFF;
        steps(48, 16'h0000);
        check("rdy_hold", 32'(upd_ready), 32'd0);
        step(16'h0000);
        check("rdy_rise", 32'(upd_ready), 32'd1);
        // accept 1234, then a refused offer while pending, then 5678 once ready returns
        steps(10, 16'h8F31);
        upd_valid = 1'b1; upd_data = 16'h1234;
        step(16'h8F31);
        upd_valid = 1'b0;
        steps(9, 16'h8F31);
        upd_valid = 1'b1; upd_data = 16'hDEAD;
        step(16'h8F31);
        check("busy_ready", 32'(upd_ready), 32'd0);
        steps(58, 16'h8F31);
        upd_data = 16'h5678;
        step(16'h8F31);
        check("ready_back", 32'(upd_ready), 32'd1);
        step(16'h1234);
        upd_valid = 1'b0;
        check("acc2_ready", 32'(upd_ready), 32'd0);
        steps(79, 16'h1234);
        // accept on the boundary edge: applied one frame later
        steps(79, 16'h5678);
        upd_valid = 1'b1; upd_data = 16'hABCD;
        step(16'h5678);
        check("bnd_acc", 32'(upd_ready), 32'd0);
        upd_valid = 1'b0;
        steps(80, 16'h5678);
        steps(30, 16'hABCD);
        // en low mid-SHOW; pending applies immediately
        en = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            check($sformatf("en_lo %0d", i), 32'(outs()), 32'({1'b0, 4'hF, 7'h7F}));
            if (i == 10) begin upd_valid = 1'b1; upd_data = 16'h0042; end
            if (i == 11) begin check("enlo_acc", 32'(upd_ready), 32'd0); upd_valid = 1'b0; end
            if (i == 12) check("enlo_apply", 32'(upd_ready), 32'd1);
        end
        en = 1'b1; ph = 0;
        steps(80, 16'h0042);
        // reset mid-scan clears active
        steps(50, 16'h0042);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_outs", 32'(outs()), 32'({1'b0, 4'hF, 7'h7F}));
        @(negedge clk);
        rst = 1'b0; ph = 0;
        steps(80, 16'h0000);
        // single significant digit (leading zeros depend on build)
        en = 1'b0; upd_valid = 1'b1; upd_data = 16'h0005;
        @(negedge clk);
        upd_valid = 1'b0;
        @(negedge clk);
        check("lz_ready", 32'(upd_ready), 32'd1);
        en = 1'b1; ph = 0;
        steps(80, 16'h0005);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/sevenseg_scan_ctrl.md
# sevenseg_scan_ctrl

Time-multiplexed scan controller for the board's common-anode seven-segment display bank. It holds NDIG 4-bit hex digit values and cycles one enabled digit at a time onto the shared active-low segment lines a–g. Between digits it inserts a blanking dead-time to suppress ghosting. Digit values are updated through a valid/ready handshake and take effect only at frame boundaries. It sits between the application logic, which produces numbers, and the static segment pins.

## Interface
- NDIG, 4: number of digits scanned; digit NDIG-1 is most significant.
- PRESCALE, 1200: clk cycles per digit slot; must be greater than DEAD.
- DEAD, 16: blanking cycles at the start of each slot; must be at least 1.
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  scan enable; low blanks the display and holds the scan at slot 0.
- upd_valid  in  1  new digit set offered.
- upd_ready  out  1  controller can accept a digit set.
- upd_data  in  4*NDIG  digit set; nibble i is digit i.
- a, b, c, d, e, f, g  out  1 each  segment drives, active-low (0 = lit).
- dig_n  out  NDIG  digit enables, active-low, at most one low at any time.
- frame_start  out  1  one-cycle pulse on the first cycle of slot 0.

## Operation
- Registers:
  - tick_cnt counts 0..PRESCALE-1.
  - dig_idx counts 0..NDIG-1.
  - active[4*NDIG] holds the digits being displayed.
  - pending[4*NDIG] plus pend_flag hold an accepted but not yet applied update.
- FSM, two states per slot:
  - BLANK while tick_cnt < DEAD: a..g = 1, dig_n = all 1.
  - SHOW while tick_cnt >= DEAD: dig_n[dig_idx] = 0, a..g = decode(active nibble dig_idx).
- Slot end and wrap:
  - When tick_cnt == PRESCALE-1: tick_cnt → 0 and dig_idx increments.
  - dig_idx wraps NDIG-1 → 0.
- Decode is full hex, active-low, in order a..g:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110
  - 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, A=0001000, b=1100000
  - C=0110001, d=1000010, E=0110000, F=0111000
- Handshake:
  - upd_ready = !pend_flag.
  - On upd_valid && upd_ready, upd_data goes to pending and pend_flag is set.
  - upd_data must be held stable only in the accepting cycle.
- Frame boundary is defined as tick_cnt == PRESCALE-1 && dig_idx == NDIG-1. On the boundary, if pend_flag is set: active ← pending and pend_flag is cleared.
- Simultaneous accept and frame boundary in the same cycle: the accept lands in pending and is applied at the next boundary, not this one.
- en low:
  - tick_cnt and dig_idx are forced to 0, the state is BLANK, and frame_start = 0.
  - Handshake and pending logic keep running.
  - With en low, pending is also applied immediately (one cycle after accept), because no frame is displayed.
- Reset mid-scan aborts the slot; everything returns to reset values, and pending and active are cleared.

## Timing
- Reset values:
  - a..g = 1, dig_n = all 1, frame_start = 0, upd_ready = 1.
  - tick_cnt = 0, dig_idx = 0, active = 0, pend_flag = 0.
- All outputs are registered. Output values in a cycle reflect the counter values of the previous cycle. a..g and dig_n switch on the same edge, with no inter-output skew.
- After rst falls with en = 1:
  - frame_start pulses on the first edge.
  - Digit 0 is blanked for DEAD cycles, then lit for PRESCALE-DEAD cycles, then slot 1 begins.
- Frame period is NDIG*PRESCALE cycles.
- Update latency is from the accept edge to the display change:
  - Applied at the next frame boundary; visible from the first SHOW cycle of slot 0.
  - Worst case is about NDIG*PRESCALE + DEAD cycles.
- upd_ready falls the cycle after accept and rises the cycle after the boundary apply.

## Configuration
- SEVENSEG_LZB_EN defined: leading-zero blanking.
  - During SHOW of digit i (i ≥ 1), dig_n stays all 1 when nibble i and every nibble above it in active are 0.
  - Digit 0 is always shown.
  - Scan timing is unchanged.
- SEVENSEG_LZB_EN undefined: every digit is lit in its slot, including leading zeros.

## Test plan
All scenarios use NDIG=4, PRESCALE=20, DEAD=4.
- Reset release, en=1, no update:
  - frame_start pulses once per 80 cycles.
  - Each slot: cycles 0–3 have dig_n=1111 and a..g=1111111; cycles 4–19 have a..g=0000001.
  - dig_n steps 1110, 1101, 1011, 0111.
- Update 0x8F31 mid-frame:
  - upd_ready drops the next cycle.
  - The display is unchanged until the boundary.
  - In the next frame: digit0=1001111, digit1=0000110, digit2=0111000, digit3=0000000.
  - upd_ready rises after the boundary.
- Second upd_valid while pend_flag is set:
  - It is not accepted (upd_ready=0).
  - The data offered on acceptance after ready returns is applied at the following boundary.
- Accept exactly on the boundary cycle: the new value appears one frame later, not in the immediately following frame.
- en held low 50 cycles mid-SHOW:
  - Next cycle: all outputs blank.
  - On en high: frame_start pulses and the scan restarts at digit 0 with 4 blank cycles.
- With SEVENSEG_LZB_EN and digits 0x0005: only digit 0 is lit, showing 0100100; slots 1–3 show dig_n=1111.
